// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: config/data link between the receive controller and a uart_rx core
interface uart_rx_ctrl_if;
    logic        rx_cfg_en_o;
    logic [15:0] rx_cfg_div_o;
    logic        rx_cfg_parity_en_o;
    logic [1:0]  rx_cfg_bits_o;
    logic        rx_cfg_stop_bits_o;
    logic        rx_err_clr_o;
    logic        rx_ready_o;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_busy_i;
    logic        rx_err_i;
    modport master (
        output rx_cfg_en_o, rx_cfg_div_o, rx_cfg_parity_en_o, rx_cfg_bits_o, rx_cfg_stop_bits_o,
        output rx_err_clr_o, rx_ready_o,
        input  rx_data_i, rx_valid_i, rx_busy_i, rx_err_i
    );
    modport slave (
        input  rx_cfg_en_o, rx_cfg_div_o, rx_cfg_parity_en_o, rx_cfg_bits_o, rx_cfg_stop_bits_o,
        input  rx_err_clr_o, rx_ready_o,
        output rx_data_i, rx_valid_i, rx_busy_i, rx_err_i
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: enable/config sequencing, receive FIFO and sticky status for a uart_rx core
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          cfg_wr_i,
    input  logic [15:0]                   cfg_div_i,
    input  logic                          cfg_parity_en_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_stop_bits_i,
    input  logic [15:0]                   timeout_cyc_i,
    input  logic [$clog2(FIFO_DEPTH):0]   irq_thresh_i,
    input  logic                          irq_clr_i,
    uart_rx_ctrl_if.master                rx,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o,
    output logic                          timeout_o,
    output logic                          err_o,
    output logic                          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [19:0] CFG_RST = {16'd868, 1'b0, 2'b11, 1'b0};

    typedef enum logic [1:0] {OFF, ON, PEND, STOP} state_t;

    state_t          state_q, state_d;
    logic [19:0]     shadow_q, shadow_d, act_q, act_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            ovr_q, ovr_d, to_q, to_d, err_q, err_d;
    logic            eprev_q, eprev_d, eclr_q, eclr_d, irq_q, irq_d;
    logic            on, dirty, acc, full, pop, push, idle, rise;

    always_comb begin
        on      = state_q != OFF;
        dirty   = shadow_q != act_q;
        state_d = state_q;
        case (state_q)
            OFF:  if (en_i) state_d = ON;
            ON:   if (!en_i) state_d = rx.rx_busy_i ? STOP : OFF;
                  else if (rx.rx_busy_i && (cfg_wr_i || dirty)) state_d = PEND;
            PEND: if (!rx.rx_busy_i) state_d = en_i ? ON : OFF;
            STOP: if (en_i) state_d = (rx.rx_busy_i && (cfg_wr_i || dirty)) ? PEND : ON;
                  else if (!rx.rx_busy_i) state_d = OFF;
            default: state_d = OFF;
        endcase
        // the active config only follows the shadow between frames
        shadow_d = cfg_wr_i ? {cfg_div_i, cfg_parity_en_i, cfg_bits_i, cfg_stop_bits_i} : shadow_q;
        act_d    = rx.rx_busy_i ? act_q : shadow_d;
    end

    always_comb begin
        full    = level_q == LW'(FIFO_DEPTH);
        acc     = rx.rx_valid_i & on;
        pop     = (level_q != '0) & ready_i;
        push    = acc & (!full | pop);
        for (int i = 0; i < FIFO_DEPTH; i++)
            mem_d[i] = (push && wptr_q == AW'(i)) ? rx.rx_data_i : mem_q[i];
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        idle    = (level_q != '0) & !push & !pop;
        cnt_d   = !idle ? '0 : (cnt_q == '1 ? cnt_q : cnt_q + 16'd1);
        rise    = rx.rx_err_i & !eprev_q;
        eprev_d = rx.rx_err_i;
        eclr_d  = rise;
        // set events take priority over irq_clr_i
        ovr_d   = (acc & full & !pop) | (ovr_q & !irq_clr_i);
        to_d    = (timeout_cyc_i != '0 && idle && cnt_d >= timeout_cyc_i) | (to_q & !irq_clr_i);
        err_d   = rise | (err_q & !irq_clr_i);
        irq_d   = (level_q >= irq_thresh_i && irq_thresh_i != '0) | ovr_q | to_q | err_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= OFF;
            shadow_q <= CFG_RST;
            act_q    <= CFG_RST;
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            to_q     <= 1'b0;
            err_q    <= 1'b0;
            eprev_q  <= 1'b0;
            eclr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            to_q     <= to_d;
            err_q    <= err_d;
            eprev_q  <= eprev_d;
            eclr_q   <= eclr_d;
            irq_q    <= irq_d;
        end
    end

    assign rx.rx_cfg_en_o  = on;
    assign rx.rx_ready_o   = on;
    assign rx.rx_err_clr_o = eclr_q;
    assign {rx.rx_cfg_div_o, rx.rx_cfg_parity_en_o, rx.rx_cfg_bits_o, rx.rx_cfg_stop_bits_o} = act_q;
    assign valid_o   = level_q != '0;
    assign data_o    = valid_o ? mem_q[rptr_q] : 8'h00;
    assign level_o   = level_q;
    assign overrun_o = ovr_q;
    assign timeout_o = to_q;
    assign err_o     = err_q;
    assign irq_o     = irq_q;
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, receive FIFO entries (power of 2, 2..16).
REQ-002 SHALL have ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- en_i  in  1  receiver enable request.
- cfg_wr_i  in  1  config load strobe.
- cfg_div_i  in  16  baud divider.
- cfg_parity_en_i  in  1  parity enable.
- cfg_bits_i  in  2  data bits minus 5.
- cfg_stop_bits_i  in  1  stop bits.
- timeout_cyc_i  in  16  idle timeout in clocks; 0 = disabled.
- irq_thresh_i  in  $clog2(FIFO_DEPTH)+1  FIFO level interrupt threshold.
- irq_clr_i  in  1  clears sticky flags.
- rx_cfg_en_o  out  1  uart_rx enable.
- rx_cfg_div_o  out  16  uart_rx divider.
- rx_cfg_parity_en_o  out  1  uart_rx parity enable.
- rx_cfg_bits_o  out  2  uart_rx bits.
- rx_cfg_stop_bits_o  out  1  uart_rx stop bits.
- rx_err_clr_o  out  1  uart_rx error clear.
- rx_ready_o  out  1  uart_rx ready.
- rx_data_i  in  8  uart_rx data.
- rx_valid_i  in  1  uart_rx valid.
- rx_busy_i  in  1  uart_rx busy.
- rx_err_i  in  1  uart_rx parity error.
- data_o  out  8  FIFO head.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer pop.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overrun_o  out  1  sticky drop flag.
- timeout_o  out  1  sticky idle timeout.
- err_o  out  1  sticky parity error.
- irq_o  out  1  registered interrupt.
REQ-003 SHALL use one clock, clk_i; reset rst_i SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be OFF, ON, PEND, STOP.
- rx_cfg_en_o = 1 in ON, PEND and STOP; 0 in OFF.
REQ-005 FSM transitions SHALL be:
- OFF->ON when en_i=1.
- ON->OFF when en_i=0 and rx_busy_i=0.
- ON->STOP when en_i=0 and rx_busy_i=1.
- STOP->OFF when rx_busy_i=0.
- STOP->ON when en_i returns to 1.
Each transition SHALL take one cycle.
REQ-006 Shadow config SHALL capture all cfg_*_i on cfg_wr_i in any state.
REQ-007 Active config (rx_cfg_*_o) SHALL copy the shadow:
- next cycle when state is OFF, or state is ON with rx_busy_i=0;
- otherwise the FSM SHALL enter PEND and copy on the first cycle rx_busy_i=0, then return to ON (or OFF if en_i=0).
The active config SHALL never change while rx_busy_i=1.
REQ-008 rx_ready_o SHALL be 1 whenever rx_cfg_en_o=1, so uart_rx never stalls mid-frame.
REQ-009 A byte SHALL be accepted when rx_valid_i & rx_ready_o.
- FIFO not full: push rx_data_i.
- FIFO full and ready_i=0: drop the byte and set overrun_o.
- Full with simultaneous pop: both occur, no overrun.
REQ-010 FIFO output timing:
- valid_o = level_o!=0; data_o = head entry.
- Pop on valid_o & ready_i.
- No bypass: a pushed byte appears on valid_o the cycle after the push.
- Pointers wrap modulo FIFO_DEPTH.
- level_o ranges 0..FIFO_DEPTH.
REQ-011 Parity error handling on rising edge of rx_err_i:
- set err_o;
- pulse rx_err_clr_o high for exactly one cycle, on the following cycle.
REQ-012 Idle timeout counter:
- counts clocks while level_o!=0 and no push or pop occurs;
- clears on push, pop, or empty;
- when count reaches timeout_cyc_i (timeout_cyc_i!=0), set timeout_o.
REQ-013 irq_clr_i SHALL clear overrun_o, timeout_o and err_o.
- A set event in the same cycle wins.
REQ-014 irq_o SHALL be registered: irq_o <= (level_o>=irq_thresh_i && irq_thresh_i!=0) | overrun_o | timeout_o | err_o.
REQ-015 FIFO contents and flags SHALL be retained across OFF; only reset clears them.

Reset
REQ-016 While rst_i=1, outputs SHALL be:
- state OFF;
- all outputs 0, except rx_cfg_div_o=16'd868 and rx_cfg_bits_o=2'b11;
- shadow config equal to active config;
- FIFO empty; timeout counter 0.
REQ-017 rst_i asserted mid-frame SHALL immediately force rx_cfg_en_o=0 and discard FIFO contents.

Verification
REQ-018 en_i=1 with cfg_div=15, frame 0xA5 received -> exactly one push; valid_o=1 with data_o=0xA5 one cycle after rx_valid_i; level_o=1.
REQ-019 Five bytes with ready_i=0 (FIFO_DEPTH=4) -> level_o=4; fifth byte dropped; overrun_o=1; irq_o=1 next cycle; irq_clr_i clears overrun_o.
REQ-020 cfg_wr_i with div=31 while rx_busy_i=1 -> state PEND; rx_cfg_div_o stays 15 until rx_busy_i falls, then 31 the next cycle.
REQ-021 en_i=0 mid-frame -> STOP; rx_cfg_en_o stays 1 until rx_busy_i=0; the frame is pushed; then OFF.
REQ-022 timeout_cyc_i=100, one byte in FIFO, no pop -> timeout_o=1 after 100 idle cycles; a pop at cycle 50 restarts the count.
REQ-023 rx_err_i 0->1 -> err_o=1; one-cycle rx_err_clr_o pulse; irq_o=1; rst_i mid-frame -> all outputs at REQ-016 values.
